// File: rtl/decoder_sched_pkg.sv
// decoder_sched_pkg
//   Shared definitions for the decoder round scheduler: FSM state codes,
//   result status codes, the cycle counter width and the PU_COUNT
//   derivation used to size the syndrome ports.
package decoder_sched_pkg;

  // Scheduler FSM states, kept as plain constants for legacy tools.
  typedef logic [1:0] sched_state_t;
  localparam sched_state_t ST_IDLE   = 2'd0;
  localparam sched_state_t ST_START  = 2'd1;
  localparam sched_state_t ST_WAIT   = 2'd2;
  localparam sched_state_t ST_REPORT = 2'd3;

  // Result status reported to the host.
  typedef enum logic [1:0] {
    STATUS_OK       = 2'd0,
    STATUS_DEADLOCK = 2'd1,
    STATUS_TIMEOUT  = 2'd2
  } status_e;

  localparam int CYCLE_COUNTER_WIDTH = 32;

  // Same MAX definition the rest of the codebase uses.
  function automatic int max_of(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  // Processing units per half: X * Z * max(X, Z).
  function automatic int pu_count_of(input int dist_x, input int dist_z);
    return dist_x * dist_z * max_of(dist_x, dist_z);
  endfunction

endpackage

// File: rtl/decoder_round_scheduler_watchdog.sv
// round_watchdog
//   Counts WAIT cycles for one decoding round. cycle_count is the 1-based
//   index of the WAIT cycle currently in progress (completed cycles + 1),
//   so a decision taken this cycle can register it directly as the number
//   of WAIT cycles consumed.
// Ports:
//   clk, reset      clock, asynchronous active-low reset
//   clear           zero the counter (frame acceptance)
//   count_en        advance the counter (high during WAIT)
//   cycle_count     index of the current WAIT cycle
//   settled         current cycle is past the settle window
//   timeout         current cycle has reached the watchdog limit
module round_watchdog
  import decoder_sched_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int SETTLE_CYCLES  = 2
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           clear,
  input  logic                           count_en,
  output logic [CYCLE_COUNTER_WIDTH-1:0] cycle_count,
  output logic                           settled,
  output logic                           timeout
);

  logic [CYCLE_COUNTER_WIDTH-1:0] count_reg;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_reg <= '0;
    end else if (clear) begin
      count_reg <= '0;
    end else if (count_en) begin
      count_reg <= cycle_count;
    end
  end

  assign cycle_count = count_reg + CYCLE_COUNTER_WIDTH'(1);
  assign settled     = cycle_count > CYCLE_COUNTER_WIDTH'(SETTLE_CYCLES);
  assign timeout     = cycle_count >= CYCLE_COUNTER_WIDTH'(TIMEOUT_CYCLES);

endmodule

// File: rtl/decoder_round_scheduler.sv
// decoder_round_scheduler
//   Sequences decoding rounds for the split left/right decoder. Accepts a
//   syndrome frame, pulses new_round_start, waits for both halves to finish
//   (or deadlock / time out), then hands one result record to the host.
// Ports:
//   clk, reset                        clock, asynchronous active-low reset
//   syndrome_in_*                     frame input handshake (left = low half)
//   left/right_is_error_syndromes     latched frame halves
//   new_round_start                   one-cycle round start pulse
//   left/right_result_valid,
//   left/right_deadlock,
//   left/right_iteration_counter      status from the two halves
//   result_out_valid/ready            result handshake
//   result_iterations/cycles/status   result record
//   rounds_completed                  results handed off (wraps)
//   busy                              scheduler not idle
module decoder_round_scheduler
  import decoder_sched_pkg::*;
#(
  parameter int CODE_DISTANCE_X         = 3,
  parameter int CODE_DISTANCE_Z         = 2,
  parameter int ITERATION_COUNTER_WIDTH = 8,
  parameter int TIMEOUT_CYCLES          = 1024,
  parameter int SETTLE_CYCLES           = 2,
  localparam int PU_COUNT = pu_count_of(CODE_DISTANCE_X, CODE_DISTANCE_Z)
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic [2*PU_COUNT-1:0]              syndrome_in_data,
  input  logic                               syndrome_in_valid,
  output logic                               syndrome_in_ready,
  output logic [PU_COUNT-1:0]                left_is_error_syndromes,
  output logic [PU_COUNT-1:0]                right_is_error_syndromes,
  output logic                               new_round_start,
  input  logic                               left_result_valid,
  input  logic                               right_result_valid,
  input  logic                               left_deadlock,
  input  logic                               right_deadlock,
  input  logic [ITERATION_COUNTER_WIDTH-1:0] left_iteration_counter,
  input  logic [ITERATION_COUNTER_WIDTH-1:0] right_iteration_counter,
  output logic                               result_out_valid,
  input  logic                               result_out_ready,
  output logic [ITERATION_COUNTER_WIDTH-1:0] result_iterations,
  output logic [31:0]                        result_cycles,
  output logic [1:0]                         result_status,
  output logic [15:0]                        rounds_completed,
  output logic                               busy
);

  sched_state_t state_reg, state_next;

  logic [PU_COUNT-1:0]                left_syn_reg, right_syn_reg;
  logic                               left_done_reg, right_done_reg;
  logic [ITERATION_COUNTER_WIDTH-1:0] left_iter_reg, right_iter_reg;
  logic [ITERATION_COUNTER_WIDTH-1:0] res_iter_reg;
  logic [31:0]                        res_cycles_reg;
  logic [1:0]                         res_status_reg;
  logic [15:0]                        rounds_reg;

  logic [31:0] cycle_count;
  logic        settled, timeout;

  logic accept, in_wait, handoff;
  logic left_hit, right_hit, left_done_now, right_done_now, deadlock_hit;
  logic decide;
  logic [ITERATION_COUNTER_WIDTH-1:0] left_iter_now, right_iter_now, iter_max;
  status_e decide_status;

  assign accept  = (state_reg == ST_IDLE) && syndrome_in_valid;
  assign in_wait = (state_reg == ST_WAIT);
  assign handoff = (state_reg == ST_REPORT) && result_out_ready;

  round_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
    .SETTLE_CYCLES (SETTLE_CYCLES)
  ) u_watchdog (
    .clk        (clk),
    .reset      (reset),
    .clear      (accept),
    .count_en   (in_wait),
    .cycle_count(cycle_count),
    .settled    (settled),
    .timeout    (timeout)
  );

  // Status inputs only count in WAIT after the settle window, which hides
  // result_valid still high from the previous round.
  assign left_hit     = in_wait && settled && left_result_valid;
  assign right_hit    = in_wait && settled && right_result_valid;
  assign deadlock_hit = in_wait && settled && (left_deadlock || right_deadlock);

  // "Now" views fold in a first assertion happening this very cycle so a
  // same-cycle finish is seen by the decision and the iteration max.
  assign left_done_now  = left_done_reg  || left_hit;
  assign right_done_now = right_done_reg || right_hit;
  assign left_iter_now  = left_done_reg  ? left_iter_reg  :
                          (left_hit  ? left_iteration_counter  : '0);
  assign right_iter_now = right_done_reg ? right_iter_reg :
                          (right_hit ? right_iteration_counter : '0);
  assign iter_max = (left_iter_now > right_iter_now) ? left_iter_now : right_iter_now;

  always_comb begin
    decide        = 1'b0;
    decide_status = STATUS_OK;
    if (deadlock_hit) begin
      decide        = 1'b1;
      decide_status = STATUS_DEADLOCK;
    end else if (in_wait && left_done_now && right_done_now) begin
      decide        = 1'b1;
      decide_status = STATUS_OK;
    end else if (in_wait && timeout) begin
      decide        = 1'b1;
      decide_status = STATUS_TIMEOUT;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE:   if (accept)  state_next = ST_START;
      ST_START:               state_next = ST_WAIT;
      ST_WAIT:   if (decide)  state_next = ST_REPORT;
      ST_REPORT: if (handoff) state_next = ST_IDLE;
      default:                state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg      <= ST_IDLE;
      left_syn_reg   <= '0;
      right_syn_reg  <= '0;
      left_done_reg  <= 1'b0;
      right_done_reg <= 1'b0;
      left_iter_reg  <= '0;
      right_iter_reg <= '0;
      res_iter_reg   <= '0;
      res_cycles_reg <= '0;
      res_status_reg <= '0;
      rounds_reg     <= '0;
    end else begin
      state_reg <= state_next;
      if (accept) begin
        left_syn_reg   <= syndrome_in_data[PU_COUNT-1:0];
        right_syn_reg  <= syndrome_in_data[2*PU_COUNT-1:PU_COUNT];
        left_done_reg  <= 1'b0;
        right_done_reg <= 1'b0;
        left_iter_reg  <= '0;
        right_iter_reg <= '0;
      end else begin
        left_done_reg  <= left_done_now;
        right_done_reg <= right_done_now;
        left_iter_reg  <= left_iter_now;
        right_iter_reg <= right_iter_now;
      end
      if (decide) begin
        res_iter_reg   <= iter_max;
        res_cycles_reg <= cycle_count;
        res_status_reg <= decide_status;
      end
      if (handoff) begin
        rounds_reg <= rounds_reg + 16'd1;
      end
    end
  end

  assign syndrome_in_ready        = (state_reg == ST_IDLE);
  assign new_round_start          = (state_reg == ST_START);
  assign result_out_valid         = (state_reg == ST_REPORT);
  assign busy                     = (state_reg != ST_IDLE);
  assign left_is_error_syndromes  = left_syn_reg;
  assign right_is_error_syndromes = right_syn_reg;
  assign result_iterations        = res_iter_reg;
  assign result_cycles            = res_cycles_reg;
  assign result_status            = res_status_reg;
  assign rounds_completed         = rounds_reg;

endmodule

// File: tb/tb_decoder_round_scheduler.sv
// tb_decoder_round_scheduler
//   Drives directed and randomized rounds. Each round is described by a
//   scenario (done/deadlock cycles, stale-valid length, iteration bases);
//   a cycle-by-cycle model of the scheduling rules predicts the result and
//   the expected phase timeline, and a negedge checker compares the DUT.
module tb_decoder_round_scheduler;

  localparam int PU = 18;
  localparam int IW = 8;
  localparam int TO = 16;
  localparam int ST = 2;

  logic            clk = 1'b0;
  logic            reset;
  logic [2*PU-1:0] syndrome_in_data;
  logic            syndrome_in_valid;
  logic            syndrome_in_ready;
  logic [PU-1:0]   left_is_error_syndromes, right_is_error_syndromes;
  logic            new_round_start;
  logic            left_result_valid, right_result_valid;
  logic            left_deadlock, right_deadlock;
  logic [IW-1:0]   left_iteration_counter, right_iteration_counter;
  logic            result_out_valid, result_out_ready;
  logic [IW-1:0]   result_iterations;
  logic [31:0]     result_cycles;
  logic [1:0]      result_status;
  logic [15:0]     rounds_completed;
  logic            busy;

  decoder_round_scheduler #(
    .CODE_DISTANCE_X        (3),
    .CODE_DISTANCE_Z        (2),
    .ITERATION_COUNTER_WIDTH(IW),
    .TIMEOUT_CYCLES         (TO),
    .SETTLE_CYCLES          (ST)
  ) dut (
    .clk                     (clk),
    .reset                   (reset),
    .syndrome_in_data        (syndrome_in_data),
    .syndrome_in_valid       (syndrome_in_valid),
    .syndrome_in_ready       (syndrome_in_ready),
    .left_is_error_syndromes (left_is_error_syndromes),
    .right_is_error_syndromes(right_is_error_syndromes),
    .new_round_start         (new_round_start),
    .left_result_valid       (left_result_valid),
    .right_result_valid      (right_result_valid),
    .left_deadlock           (left_deadlock),
    .right_deadlock          (right_deadlock),
    .left_iteration_counter  (left_iteration_counter),
    .right_iteration_counter (right_iteration_counter),
    .result_out_valid        (result_out_valid),
    .result_out_ready        (result_out_ready),
    .result_iterations       (result_iterations),
    .result_cycles           (result_cycles),
    .result_status           (result_status),
    .rounds_completed        (rounds_completed),
    .busy                    (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    int ld; int rd;   // first WAIT cycle each half raises result_valid (0 = never)
    int ls;           // result_valid also high on WAIT cycles 1..ls (stale)
    int dl; int dr;   // single WAIT cycle each half pulses deadlock (0 = never)
    int bl; int br;   // iteration counter value at the half's done cycle
  } scen_t;

  scen_t sc;
  int    errors = 0;
  int    checks = 0;
  bit    chk_en = 1'b0;

  // Expected phase: 0 idle, 1 start, 2 wait, 3 report.
  int            exp_phase;
  logic [PU-1:0] exp_left, exp_right;
  logic [15:0]   exp_rounds;
  int            exp_st, exp_cyc, exp_it;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endtask

  function automatic logic f_valid(input int d, input int ls, input int c);
    return (d != 0 && c >= d) || (c <= ls);
  endfunction

  // Counter keeps running after done so a re-capture would be visible.
  function automatic logic [IW-1:0] f_iter(input int d, input int b, input int c);
    if (d != 0 && c >= d) return IW'(b + c - d);
    return IW'(8'hA0 + c);
  endfunction

  function automatic logic f_dead(input int d, input int c);
    return (d != 0) && (c == d);
  endfunction

  // Result of a round from the scheduling rules, one WAIT cycle at a time.
  task automatic model(input scen_t s, output int st, output int cyc, output int it);
    int li, ri;
    bit lok, rok, fin;
    li = 0; ri = 0; lok = 0; rok = 0; fin = 0;
    st = 2; cyc = TO; it = 0;
    for (int c = 1; c <= TO; c++) begin
      if (!fin && c > ST) begin
        if (!lok && f_valid(s.ld, s.ls, c)) begin lok = 1; li = int'(f_iter(s.ld, s.bl, c)); end
        if (!rok && f_valid(s.rd, s.ls, c)) begin rok = 1; ri = int'(f_iter(s.rd, s.br, c)); end
        if (f_dead(s.dl, c) || f_dead(s.dr, c)) begin
          st = 1; cyc = c; fin = 1;
        end else if (lok && rok) begin
          st = 0; cyc = c; fin = 1;
        end
      end
    end
    it = (li > ri) ? li : ri;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Status inputs outside WAIT must be ignored, so make them noisy.
  task automatic drive_junk();
    left_result_valid       = 1'($urandom);
    right_result_valid      = 1'($urandom);
    left_deadlock           = 1'($urandom);
    right_deadlock          = 1'($urandom);
    left_iteration_counter  = IW'($urandom);
    right_iteration_counter = IW'($urandom);
  endtask

  task automatic drive_wait(input int c);
    left_result_valid       = f_valid(sc.ld, sc.ls, c);
    right_result_valid      = f_valid(sc.rd, sc.ls, c);
    left_deadlock           = f_dead(sc.dl, c);
    right_deadlock          = f_dead(sc.dr, c);
    left_iteration_counter  = f_iter(sc.ld, sc.bl, c);
    right_iteration_counter = f_iter(sc.rd, sc.br, c);
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("syndrome_in_ready", 64'(syndrome_in_ready), 64'(exp_phase == 0));
      chk("new_round_start",   64'(new_round_start),   64'(exp_phase == 1));
      chk("busy",              64'(busy),              64'(exp_phase != 0));
      chk("result_out_valid",  64'(result_out_valid),  64'(exp_phase == 3));
      chk("rounds_completed",  64'(rounds_completed),  64'(exp_rounds));
      chk("left_syndromes",    64'(left_is_error_syndromes),  64'(exp_left));
      chk("right_syndromes",   64'(right_is_error_syndromes), 64'(exp_right));
      if (exp_phase == 3) begin
        chk("result_status",     64'(result_status),     64'(exp_st));
        chk("result_cycles",     64'(result_cycles),     64'(exp_cyc));
        chk("result_iterations", 64'(result_iterations), 64'(exp_it));
      end
    end
  end

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_ready"},  64'(syndrome_in_ready), 64'd1);
    chk({tag, "_nrs"},    64'(new_round_start),   64'd0);
    chk({tag, "_busy"},   64'(busy),              64'd0);
    chk({tag, "_valid"},  64'(result_out_valid),  64'd0);
    chk({tag, "_rounds"}, 64'(rounds_completed),  64'd0);
    chk({tag, "_lsyn"},   64'(left_is_error_syndromes),  64'd0);
    chk({tag, "_rsyn"},   64'(right_is_error_syndromes), 64'd0);
    chk({tag, "_status"}, 64'(result_status),     64'd0);
    chk({tag, "_cycles"}, 64'(result_cycles),     64'd0);
    chk({tag, "_iters"},  64'(result_iterations), 64'd0);
  endtask

  // One full round; rst_at > 0 asserts reset during that WAIT cycle instead.
  task automatic run_round(input scen_t s, input int hold, input logic [2*PU-1:0] frame,
                           input int rst_at, input int id);
    int est, ecyc, eit;
    model(s, est, ecyc, eit);
    sc = s;
    syndrome_in_valid = 1'b1;
    syndrome_in_data  = frame;
    drive_junk();
    step();
    exp_phase = 1;
    exp_left  = frame[PU-1:0];
    exp_right = frame[2*PU-1:PU];
    // Keep offering a different frame: it must not be taken while busy.
    syndrome_in_data = {4'($urandom), $urandom};
    drive_junk();
    step();
    for (int c = 1; c <= ecyc; c++) begin
      exp_phase = 2;
      drive_wait(c);
      if (rst_at == c) begin
        reset             = 1'b0;
        syndrome_in_valid = 1'b0;
        exp_phase  = 0;
        exp_left   = '0;
        exp_right  = '0;
        exp_rounds = '0;
        #1;
        check_reset_outputs("midwait_reset");
        step();
        step();
        reset = 1'b1;
        step();
        $display("round %0d: reset during WAIT cycle %0d, no result", id, c);
        return;
      end
      step();
    end
    exp_st = est; exp_cyc = ecyc; exp_it = eit;
    exp_phase = 3;
    for (int h = 0; h < hold; h++) begin
      result_out_ready = 1'b0;
      drive_junk();
      step();
    end
    result_out_ready = 1'b1;
    drive_junk();
    step();
    exp_rounds = exp_rounds + 16'd1;
    exp_phase = 0;
    result_out_ready  = 1'b0;
    syndrome_in_valid = 1'b0;
    $display("round %0d: status=%0d cycles=%0d iters=%0d (dut %0d/%0d/%0d) rounds=%0d",
             id, est, ecyc, eit, result_status, result_cycles, result_iterations, rounds_completed);
  endtask

  initial begin
    scen_t s;
    int    m_st, m_cyc, m_it;
    reset = 1'b0;
    syndrome_in_data  = '0;
    syndrome_in_valid = 1'b0;
    result_out_ready  = 1'b0;
    left_result_valid = 1'b0; right_result_valid = 1'b0;
    left_deadlock     = 1'b0; right_deadlock     = 1'b0;
    left_iteration_counter = '0; right_iteration_counter = '0;
    exp_phase = 0; exp_left = '0; exp_right = '0; exp_rounds = '0;
    exp_st = 0; exp_cyc = 0; exp_it = 0;
    step();
    step();
    check_reset_outputs("por");
    chk_en = 1'b1;
    reset  = 1'b1;
    step();

    // Pin the model on hand-computed cases.
    s = '{ld:5, rd:5, ls:0, dl:0, dr:0, bl:3, br:7};
    model(s, m_st, m_cyc, m_it);
    chk("model_basic_status", 64'(m_st), 64'd0);
    chk("model_basic_cycles", 64'(m_cyc), 64'd5);
    chk("model_basic_iters",  64'(m_it), 64'd7);
    run_round(s, 0, 36'h1 << PU, 0, 1);

    s = '{ld:4, rd:4, ls:2, dl:0, dr:0, bl:9, br:2};
    model(s, m_st, m_cyc, m_it);
    chk("model_stale_cycles", 64'(m_cyc), 64'd4);
    left_result_valid = 1'b1; right_result_valid = 1'b1;
    run_round(s, 1, 36'hF_0000_0001, 0, 2);

    s = '{ld:6, rd:0, ls:0, dl:0, dr:6, bl:5, br:1};
    model(s, m_st, m_cyc, m_it);
    chk("model_deadlock_status", 64'(m_st), 64'd1);
    chk("model_deadlock_cycles", 64'(m_cyc), 64'd6);
    run_round(s, 0, 36'h5_5555_5555, 0, 3);

    s = '{ld:0, rd:0, ls:0, dl:0, dr:0, bl:0, br:0};
    model(s, m_st, m_cyc, m_it);
    chk("model_timeout_status", 64'(m_st), 64'd2);
    chk("model_timeout_cycles", 64'(m_cyc), 64'd16);
    chk("model_timeout_iters",  64'(m_it), 64'd0);
    run_round(s, 2, 36'hA_AAAA_AAAA, 0, 4);

    s = '{ld:16, rd:16, ls:0, dl:0, dr:0, bl:4, br:4};
    model(s, m_st, m_cyc, m_it);
    chk("model_boundary_status", 64'(m_st), 64'd0);
    chk("model_boundary_cycles", 64'(m_cyc), 64'd16);
    run_round(s, 0, 36'h0_1234_5678, 0, 5);

    s = '{ld:3, rd:8, ls:0, dl:0, dr:0, bl:1, br:2};
    run_round(s, 10, 36'h8_0000_0000, 0, 6);

    s = '{ld:10, rd:10, ls:0, dl:0, dr:0, bl:1, br:1};
    run_round(s, 0, 36'h3_C3C3_C3C3, 5, 7);

    for (int r = 0; r < 24; r++) begin
      s.ld = $urandom_range(0, 18);
      s.rd = $urandom_range(0, 18);
      s.ls = $urandom_range(0, 3);
      s.dl = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 16) : 0;
      s.dr = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 16) : 0;
      s.bl = $urandom_range(0, 255);
      s.br = $urandom_range(0, 255);
      for (int g = 0; g < int'($urandom_range(0, 2)); g++) begin
        drive_junk();
        step();
      end
      run_round(s, $urandom_range(0, 3), {4'($urandom), $urandom}, 0, 8 + r);
    end

    step();
    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
